// File: rtl/elevator_pkg.sv
// elevator_pkg: state encoding and sizing helper shared by the elevator controller files
package elevator_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MOVE = 2'd1, ST_DOOR = 2'd2} state_t;
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/elevator_timer.sv
// elevator_timer: loadable down-counter shared by floor travel and door dwell
module elevator_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         done
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (load) count <= load_val;
        else if (count != '0) count <= count - W'(1);
    assign done = (count == '0);
endmodule

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: N-floor SCAN elevator controller with per-floor travel time and timed door dwell
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] req,
    output logic [FLOOR_W-1:0]    floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);
    localparam int TW = $clog2(max_int(TRAVEL_CYCLES, DOOR_CYCLES) + 1);
    localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LD = TW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);
    state_t state, state_d;
    logic [FLOOR_W-1:0] floor_d;
    logic dir_d, dir_n, load, done;
    logic [TW-1:0] load_val, tmr;
    logic [NUM_FLOORS-1:0] here, below, above, ahead, behind, clr;
    elevator_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .count    (tmr),
        .done     (done)
    );
    always_comb begin
        here     = NUM_FLOORS'(1) << floor;
        below    = here - NUM_FLOORS'(1);
        above    = ~(below | here);
        ahead    = pending & (dir_up ? above : below);
        behind   = pending & (dir_up ? below : above);
        state_d  = state;
        floor_d  = floor;
        dir_d    = dir_up;
        clr      = '0;
        load     = 1'b0;
        load_val = TRAVEL_LD;
        unique case (state)
            ST_IDLE:
                if (|(pending & here)) begin
                    state_d  = ST_DOOR;
                    clr      = here;
                    load     = 1'b1;
                    load_val = DOOR_LD;
                end else if (|ahead) begin
                    state_d = ST_MOVE;
                    load    = 1'b1;
                end else if (|behind) begin
                    state_d = ST_MOVE;
                    load    = 1'b1;
                    dir_d   = ~dir_up;
                end
            ST_MOVE:
                if (done) begin
                    state_d = ST_IDLE;
                    floor_d = dir_up ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
                end
            ST_DOOR: begin
                // calls for this floor are absorbed while open and only extend the dwell
                clr      = here;
                load_val = DOOR_LD;
                if (|(req & here)) load = 1'b1;
                else if (tmr == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        dir_n = (floor_d == '0) ? 1'b1 : (floor_d == TOP) ? 1'b0 : dir_d;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= ST_IDLE;
            floor   <= '0;
            dir_up  <= 1'b1;
            pending <= '0;
        end else begin
            state   <= state_d;
            floor   <= floor_d;
            dir_up  <= dir_n;
            pending <= (pending | req) & ~clr;
        end
    assign moving    = (state == ST_MOVE);
    assign door_open = (state == ST_DOOR);
endmodule
